// File: rtl/disassembler.sv
// Streaming RV32I disassembler: takes one instruction word per handshake and
// emits its assembly text one ASCII character per accepted cycle, ending in "\n".
package constants;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
endpackage

module disassembler
  import constants::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] instruction,
  input  logic        inst_valid,
  output logic        inst_ready,
  output logic [7:0]  out_char,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        line_done,
  output logic        error_flag
);

  typedef enum logic [2:0] {IDLE, DECODE, MNEM, SPACE, REG, SEP, IMM, EOL} state_t;

  function automatic logic [2:0] mn_length(input logic [4:0][7:0] s);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 5; i++)
      if (s[i] != 8'd0) n = n + 3'd1;
    return n;
  endfunction

  function automatic logic [20:0] magnitude(input logic signed [31:0] v);
    return 21'(v[31] ? -v : v);
  endfunction

  function automatic logic [2:0] top_nibble(input logic [20:0] m);
    logic [23:0] w;
    logic [2:0]  t;
    w = {3'd0, m};
    t = 3'd0;
    for (int i = 0; i < 6; i++)
      if (w[i*4 +: 4] != 4'd0) t = 3'(i);
    return t;
  endfunction

  // Decimal split by comparison against 10/20/30 rather than a divider.
  function automatic logic [1:0] reg_tens(input logic [4:0] r);
    if (r >= 5'd30) return 2'd3;
    if (r >= 5'd20) return 2'd2;
    if (r >= 5'd10) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [3:0] reg_ones(input logic [4:0] r);
    case (reg_tens(r))
      2'd3:    return 4'(r - 5'd30);
      2'd2:    return 4'(r - 5'd20);
      2'd1:    return 4'(r - 5'd10);
      default: return r[3:0];
    endcase
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'd0, n} : 8'h57 + {4'd0, n};
  endfunction

  state_t      state, nxt_state;
  logic [2:0]  idx, nxt_idx;
  logic [1:0]  op, nxt_op;
  logic [2:0]  nib, nxt_nib;
  logic [7:0]  nxt_char;

  logic [31:0] instr;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic signed [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u  = {12'd0, instr[31:12]};
  assign imm_sh = {27'd0, instr[24:20]};

  logic [4:0][7:0]    dec_mn;
  logic [2:0]         dec_len;
  logic [1:0]         dec_nregs;
  logic               dec_imm, dec_illegal;
  logic [4:0]         dec_regs [4];
  logic signed [31:0] dec_val;
  logic [20:0]        dec_mag;

  // Operands are listed registers first; the immediate, when present, is always last.
  always_comb begin
    dec_mn      = {16'd0, "???"};
    dec_nregs   = 2'd0;
    dec_imm     = 1'b0;
    dec_regs[0] = rd;
    dec_regs[1] = rs1;
    dec_regs[2] = rs2;
    dec_regs[3] = 5'd0;
    dec_val     = imm_i;
    case (opcode)
      OP_REG: begin
        dec_nregs = 2'd3;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'd0: dec_mn = {16'd0, "add"};
            3'd1: dec_mn = {16'd0, "sll"};
            3'd2: dec_mn = {16'd0, "slt"};
            3'd3: dec_mn = {8'd0, "sltu"};
            3'd4: dec_mn = {16'd0, "xor"};
            3'd5: dec_mn = {16'd0, "srl"};
            3'd6: dec_mn = {24'd0, "or"};
            default: dec_mn = {16'd0, "and"};
          endcase
        end else if (f7 == 7'b0100000) begin
          case (f3)
            3'd0: dec_mn = {16'd0, "sub"};
            3'd5: dec_mn = {16'd0, "sra"};
            default: ;
          endcase
        end
      end
      OP_IMM: begin
        dec_nregs = 2'd2;
        dec_imm   = 1'b1;
        case (f3)
          3'd0: dec_mn = {8'd0, "addi"};
          3'd2: dec_mn = {8'd0, "slti"};
          3'd3: dec_mn = "sltiu";
          3'd4: dec_mn = {8'd0, "xori"};
          3'd6: dec_mn = {16'd0, "ori"};
          3'd7: dec_mn = {8'd0, "andi"};
          3'd1: begin
            dec_val = imm_sh;
            if (f7 == 7'b0000000) dec_mn = {8'd0, "slli"};
          end
          default: begin
            dec_val = imm_sh;
            if (f7 == 7'b0000000)      dec_mn = {8'd0, "srli"};
            else if (f7 == 7'b0100000) dec_mn = {8'd0, "srai"};
          end
        endcase
      end
      OP_LOAD: begin
        dec_nregs = 2'd2;
        dec_imm   = 1'b1;
        case (f3)
          3'd0: dec_mn = {24'd0, "lb"};
          3'd1: dec_mn = {24'd0, "lh"};
          3'd2: dec_mn = {24'd0, "lw"};
          3'd4: dec_mn = {16'd0, "lbu"};
          3'd5: dec_mn = {16'd0, "lhu"};
          default: ;
        endcase
      end
      OP_STORE: begin
        dec_nregs   = 2'd2;
        dec_imm     = 1'b1;
        dec_regs[0] = rs2;
        dec_regs[1] = rs1;
        dec_val     = imm_s;
        case (f3)
          3'd0: dec_mn = {24'd0, "sb"};
          3'd1: dec_mn = {24'd0, "sh"};
          3'd2: dec_mn = {24'd0, "sw"};
          default: ;
        endcase
      end
      OP_BRANCH: begin
        dec_nregs   = 2'd2;
        dec_imm     = 1'b1;
        dec_regs[0] = rs1;
        dec_regs[1] = rs2;
        dec_val     = imm_b;
        case (f3)
          3'd0: dec_mn = {16'd0, "beq"};
          3'd1: dec_mn = {16'd0, "bne"};
          3'd4: dec_mn = {16'd0, "blt"};
          3'd5: dec_mn = {16'd0, "bge"};
          3'd6: dec_mn = {8'd0, "bltu"};
          3'd7: dec_mn = {8'd0, "bgeu"};
          default: ;
        endcase
      end
      OP_LUI: begin
        dec_nregs = 2'd1;
        dec_imm   = 1'b1;
        dec_val   = imm_u;
        dec_mn    = {16'd0, "lui"};
      end
      OP_AUIPC: begin
        dec_nregs = 2'd1;
        dec_imm   = 1'b1;
        dec_val   = imm_u;
        dec_mn    = "auipc";
      end
      OP_JAL: begin
        dec_nregs = 2'd1;
        dec_imm   = 1'b1;
        dec_val   = imm_j;
        dec_mn    = {16'd0, "jal"};
      end
      OP_JALR: begin
        dec_nregs = 2'd2;
        dec_imm   = 1'b1;
        if (f3 == 3'd0) dec_mn = {8'd0, "jalr"};
      end
      default: ;
    endcase
    dec_illegal = (dec_mn == {16'd0, "???"});
    if (dec_illegal) begin
      dec_nregs = 2'd0;
      dec_imm   = 1'b0;
    end
  end

  assign dec_len = mn_length(dec_mn);
  assign dec_mag = magnitude(dec_val);

  logic [4:0][7:0] mn;
  logic [2:0]      mn_len;
  logic [1:0]      n_regs, n_ops;
  logic            has_imm, neg, last_op;
  logic [4:0]      regs [4];
  logic [20:0]     mag;
  logic [23:0]     mag24;
  logic [2:0]      top;

  always_ff @(posedge clk_in) begin
    if (state == IDLE && inst_valid) instr <= instruction;
    if (state == DECODE) begin
      mn      <= dec_mn;
      mn_len  <= dec_len;
      n_regs  <= dec_nregs;
      has_imm <= dec_imm;
      regs    <= dec_regs;
      neg     <= dec_val[31];
      mag     <= dec_mag;
      top     <= top_nibble(dec_mag);
    end
  end

  assign n_ops   = n_regs + {1'b0, has_imm};
  assign last_op = (op == n_ops - 2'd1);
  assign mag24   = {3'd0, mag};

  // Position that follows the current character once it is accepted.
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_op    = op;
    nxt_nib   = nib;
    case (state)
      MNEM: begin
        if (idx == mn_len - 3'd1) nxt_state = (n_ops == 2'd0) ? EOL : SPACE;
        else                      nxt_idx   = idx + 3'd1;
      end
      SPACE, SEP: begin
        nxt_op = (state == SPACE) ? 2'd0 : op + 2'd1;
        if (nxt_op < n_regs) begin
          nxt_state = REG;
          nxt_idx   = 3'd0;
        end else begin
          nxt_state = IMM;
          nxt_idx   = neg ? 3'd0 : 3'd1;
        end
      end
      REG: begin
        case (idx)
          3'd0:    nxt_idx = (regs[op] >= 5'd10) ? 3'd1 : 3'd2;
          3'd1:    nxt_idx = 3'd2;
          default: nxt_state = last_op ? EOL : SEP;
        endcase
      end
      IMM: begin
        case (idx)
          3'd0, 3'd1: nxt_idx = idx + 3'd1;
          3'd2: begin
            nxt_idx = 3'd3;
            nxt_nib = top;
          end
          default: begin
            if (nib == 3'd0) nxt_state = EOL;
            else             nxt_nib   = nib - 3'd1;
          end
        endcase
      end
      EOL: begin
        nxt_state = IDLE;
        nxt_idx   = 3'd0;
        nxt_op    = 2'd0;
        nxt_nib   = 3'd0;
      end
      default: ;
    endcase
  end

  always_comb begin
    nxt_char = 8'h00;
    case (nxt_state)
      MNEM:  nxt_char = mn[mn_len - 3'd1 - nxt_idx];
      SPACE: nxt_char = " ";
      SEP:   nxt_char = ",";
      REG: begin
        case (nxt_idx)
          3'd0:    nxt_char = "x";
          3'd1:    nxt_char = 8'h30 + {6'd0, reg_tens(regs[nxt_op])};
          default: nxt_char = 8'h30 + {4'd0, reg_ones(regs[nxt_op])};
        endcase
      end
      IMM: begin
        case (nxt_idx)
          3'd0:    nxt_char = "-";
          3'd1:    nxt_char = "0";
          3'd2:    nxt_char = "x";
          default: nxt_char = hex_char(mag24[{nxt_nib, 2'b00} +: 4]);
        endcase
      end
      EOL:     nxt_char = 8'h0A;
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= IDLE;
      idx        <= 3'd0;
      op         <= 2'd0;
      nib        <= 3'd0;
      out_char   <= 8'h00;
      char_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (inst_valid) state <= DECODE;
        DECODE: begin
          state      <= MNEM;
          idx        <= 3'd0;
          op         <= 2'd0;
          nib        <= 3'd0;
          out_char   <= dec_mn[dec_len - 3'd1];
          char_valid <= 1'b1;
        end
        default: begin
          if (char_ready) begin
            state      <= nxt_state;
            idx        <= nxt_idx;
            op         <= nxt_op;
            nib        <= nxt_nib;
            out_char   <= nxt_char;
            char_valid <= (nxt_state != IDLE);
          end
        end
      endcase
    end
  end

  assign inst_ready = (state == IDLE);
  assign line_done  = (state == EOL) && char_ready;
  assign error_flag = (state == DECODE) && dec_illegal;

endmodule

// File: tb/tb_disassembler.sv
// Directed bench for the RV32I disassembler: table of words with expected text,
// plus backpressure and mid-line reset sequences.
module tb_disassembler;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] instruction;
  logic        inst_valid;
  logic        inst_ready;
  logic [7:0]  out_char;
  logic        char_valid;
  logic        char_ready;
  logic        line_done;
  logic        error_flag;

  always #5 clk_in = ~clk_in;

  disassembler dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .instruction (instruction),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .out_char    (out_char),
    .char_valid  (char_valid),
    .char_ready  (char_ready),
    .line_done   (line_done),
    .error_flag  (error_flag)
  );

  typedef struct {
    logic [31:0] word;
    string       text;
    bit          illegal;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] w, input string t, input bit ill);
    vec_t v;
    v.word    = w;
    v.text    = t;
    v.illegal = ill;
    vecs.push_back(v);
  endtask

  // Present one word and collect its line; stall lowers char_ready for 3 cycles
  // before every odd-indexed character, hold keeps inst_valid high throughout.
  task automatic run_word(input logic [31:0] word, input string txt, input bit ill,
                          input bit stall, input bit hold);
    int pos;
    int stall_left;
    int n;
    n = txt.len();
    @(negedge clk_in);
    instruction = word;
    inst_valid  = 1'b1;
    #1;
    check($sformatf("idle_ready %h", word), inst_ready, 1);
    @(negedge clk_in);
    inst_valid = hold;
    #1;
    check($sformatf("decode_no_char %h", word), char_valid, 0);
    check($sformatf("decode_error_flag %h", word), error_flag, ill);
    check($sformatf("decode_busy %h", word), inst_ready, 0);
    pos = 0;
    stall_left = 0;
    while (pos < n) begin
      @(negedge clk_in);
      char_ready = (stall_left == 0);
      #1;
      check($sformatf("char_valid %h pos%0d", word, pos), char_valid, 1);
      check($sformatf("char %h pos%0d", word, pos), out_char, txt[pos]);
      check($sformatf("line_done %h pos%0d", word, pos), line_done,
            (char_ready && pos == n - 1));
      check($sformatf("error_quiet %h pos%0d", word, pos), error_flag, 0);
      if (hold) check($sformatf("busy_hold %h pos%0d", word, pos), inst_ready, 0);
      if (char_ready) begin
        pos++;
        stall_left = (stall && (pos % 2 == 1)) ? 3 : 0;
      end else begin
        stall_left--;
      end
    end
    @(negedge clk_in);
    #1;
    check($sformatf("ready_after_line %h", word), inst_ready, 1);
    check($sformatf("no_char_after_line %h", word), char_valid, 0);
    check($sformatf("line_done_clear %h", word), line_done, 0);
    inst_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    rst_in      = 1'b1;
    inst_valid  = 1'b0;
    instruction = 32'd0;
    char_ready  = 1'b0;
    repeat (2) @(negedge clk_in);
    #1;
    check("reset_inst_ready", inst_ready, 1);
    check("reset_char_valid", char_valid, 0);
    check("reset_out_char", out_char, 8'h00);
    check("reset_line_done", line_done, 0);
    check("reset_error_flag", error_flag, 0);
    rst_in = 1'b0;

    add_vec(32'h003100B3, "add x1,x2,x3\n", 1'b0);
    add_vec(32'hFFF00293, "addi x5,x0,-0x1\n", 1'b0);
    add_vec(32'h00000013, "addi x0,x0,0x0\n", 1'b0);
    add_vec(32'h12345537, "lui x10,0x12345\n", 1'b0);
    add_vec(32'hFE208CE3, "beq x1,x2,-0x8\n", 1'b0);
    add_vec(32'h01F12623, "sw x31,x2,0xc\n", 1'b0);
    add_vec(32'h00000000, "???\n", 1'b1);
    add_vec(32'h40525193, "srai x3,x4,0x5\n", 1'b0);
    add_vec(32'h800000EF, "jal x1,-0x100000\n", 1'b0);
    add_vec(32'hFF0A2603, "lw x12,x20,-0x10\n", 1'b0);
    add_vec(32'h01DF3FB3, "sltu x31,x30,x29\n", 1'b0);
    add_vec(32'h40001033, "???\n", 1'b1);
    add_vec(32'hFFFFF117, "auipc x2,0xfffff\n", 1'b0);
    add_vec(32'h00008067, "jalr x0,x1,0x0\n", 1'b0);

    foreach (vecs[i]) run_word(vecs[i].word, vecs[i].text, vecs[i].illegal, 1'b0, 1'b0);

    run_word(32'h003100B3, "add x1,x2,x3\n", 1'b0, 1'b1, 1'b1);

    // Reset while the mnemonic is being emitted.
    @(negedge clk_in);
    instruction = 32'h003100B3;
    inst_valid  = 1'b1;
    char_ready  = 1'b1;
    @(negedge clk_in);
    inst_valid = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    #1;
    check("pre_reset_char", out_char, "d");
    #2;
    rst_in = 1'b1;
    #1;
    check("midline_rst_char_valid", char_valid, 0);
    check("midline_rst_inst_ready", inst_ready, 1);
    check("midline_rst_out_char", out_char, 8'h00);
    check("midline_rst_line_done", line_done, 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    run_word(32'hFFF00293, "addi x5,x0,-0x1\n", 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
